// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Purpose
//   Sits between the execute stage and a byte-addressable data memory that
//   has a single address/write port. Stores are queued in program order
//   (up to DEPTH entries) and retired one per cycle into the memory. Loads
//   take the port whenever they do not collide with a buffered store. A load
//   that exactly matches the youngest overlapping store can be served
//   directly from the buffer (store-to-load forwarding).
//
// Configuration
//   STORE_BUF_FWD_EN : when defined, exact-match loads are forwarded.
//                      When undefined, fwd_hit/fwd_data are tied to 0, any
//                      overlap raises ld_conflict and no forwarding
//                      comparators or sign-extension logic are built.
//
// Parameters
//   DEPTH       entry count, power of two, >= 2
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (drops all pending stores)
//   st_valid    store request from execute
//   st_ready    buffer can accept a store (= !full)
//   st_addr     store byte address
//   st_data     store data, LSB-aligned
//   st_mode     00 byte, 01 halfword, 10 word, 11 treated as byte
//   ld_valid    a load wants the memory port this cycle
//   ld_addr     load byte address
//   ld_mode     load size, same encoding as st_mode
//   ld_conflict load overlaps a buffered store it cannot be forwarded from;
//               the caller must stall and retry
//   fwd_hit     load is served from the buffer this cycle
//   fwd_data    forwarded data, sign-extended like a memory read
//   mem_we      memory write enable (a store is draining)
//   mem_mode    memory access size
//   mem_addr    memory address (load address or draining store address)
//   mem_wdata   data of the oldest buffered store, 0 when empty
//   empty       no stores pending (fence / drain status)
//
// Handshake
//   A store transfers on a rising edge where st_valid && st_ready. The
//   requester holds st_addr/st_data/st_mode stable while st_valid is high and
//   st_ready is low. st_ready depends only on the occupancy register, never
//   on st_valid, and is strictly !full: a drain in the same cycle does not
//   free a slot for a store arriving while full.
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_mode,

    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_mode,
    output logic        ld_conflict,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,

    output logic        mem_we,
    output logic [1:0]  mem_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,

    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Access size in bytes; the unused encoding 11 behaves as a byte.
    function automatic logic [2:0] mode_size(input logic [1:0] mode);
        logic [2:0] size;
        case (mode)
            2'b01:   size = 3'd2;
            2'b10:   size = 3'd4;
            default: size = 3'd1;
        endcase
        return size;
    endfunction

    // Address of the last byte touched. Plain 32-bit arithmetic: an access
    // that would wrap past 0xFFFFFFFF is not treated specially.
    function automatic logic [31:0] last_byte(input logic [31:0] addr,
                                              input logic [1:0]  mode);
        return addr + {29'd0, mode_size(mode)} - 32'd1;
    endfunction

`ifdef STORE_BUF_FWD_EN
    // Forwarded data looks exactly like a memory read of the same size.
    function automatic logic [31:0] sign_extend(input logic [31:0] data,
                                                input logic [1:0]  mode);
        logic [31:0] ext;
        case (mode_size(mode))
            3'd1:    ext = {{24{data[7]}},  data[7:0]};
            3'd2:    ext = {{16{data[15]}}, data[15:0]};
            default: ext = data;
        endcase
        return ext;
    endfunction
`endif

    // -----------------------------------------------------------------------
    // Storage and pointers
    // -----------------------------------------------------------------------
    logic [31:0]      ent_addr  [DEPTH];
    logic [31:0]      ent_data  [DEPTH];
    logic [1:0]       ent_mode  [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic full;
    logic is_empty;
    logic enq;
    logic drain;
    logic load_owns;

    assign full     = (count == CNT_W'(DEPTH));
    assign is_empty = (count == '0);
    assign st_ready = !full;
    assign empty    = is_empty;
    assign enq      = st_valid && !full;

    // -----------------------------------------------------------------------
    // Overlap detection against every live entry
    // -----------------------------------------------------------------------
    logic [31:0]      ld_last;
    logic [DEPTH-1:0] ovl_vec;

    assign ld_last = last_byte(ld_addr, ld_mode);

    always_comb begin
        ovl_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ovl_vec[i] = ent_valid[i]
                      && (ld_addr <= last_byte(ent_addr[i], ent_mode[i]))
                      && (ent_addr[i] <= ld_last);
        end
    end

    // Walk entries from oldest to youngest; the last overlapping one seen is
    // the youngest, which is the only one whose value a load may observe.
    logic             any_overlap;
    logic [PTR_W-1:0] young_idx;
    logic [PTR_W-1:0] scan_idx;

    always_comb begin
        any_overlap = 1'b0;
        young_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PTR_W'(k);
            if (ovl_vec[scan_idx]) begin
                any_overlap = 1'b1;
                young_idx   = scan_idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding
    // -----------------------------------------------------------------------
`ifdef STORE_BUF_FWD_EN
    logic exact_match;

    // Equal size rather than equal mode: 00 and 11 both mean one byte.
    assign exact_match = (ent_addr[young_idx] == ld_addr)
                      && (mode_size(ent_mode[young_idx]) == mode_size(ld_mode));
    assign fwd_hit     = ld_valid && any_overlap && exact_match;
    assign fwd_data    = fwd_hit ? sign_extend(ent_data[young_idx], ld_mode)
                                 : 32'd0;
`else
    assign fwd_hit     = 1'b0;
    assign fwd_data    = 32'd0;
`endif

    assign ld_conflict = ld_valid && any_overlap && !fwd_hit;

    // -----------------------------------------------------------------------
    // Port arbitration
    //   A non-conflicting load (forwarded or not) owns the port. Otherwise
    //   the oldest store drains; a conflicting load therefore forces a drain
    //   every cycle, so the conflict clears after at most `count` cycles.
    // -----------------------------------------------------------------------
    assign load_owns = ld_valid && !ld_conflict;
    assign drain     = !is_empty && !load_owns;

    assign mem_we    = drain;
    assign mem_addr  = drain ? ent_addr[head] : ld_addr;
    assign mem_mode  = drain ? ent_mode[head] : ld_mode;
    assign mem_wdata = is_empty ? 32'd0 : ent_data[head];

    // -----------------------------------------------------------------------
    // Control state
    //   head and tail can only coincide when empty or full, so an enqueue
    //   (needs !full) and a drain (needs !empty) never touch the same slot.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (enq) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (drain) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            case ({enq, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; ent_valid gates every use of it.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
            ent_mode[tail] <= st_mode;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Directed bench for store_buffer (DEPTH = 4). Every accepted store pushes
// its expected memory write {addr, mode, data} into exp_q; a monitor pops
// and compares whenever the DUT asserts mem_we, so drain order and contents
// are checked independently of the stimulus. Load-side outputs are checked
// directly by the driver in the cycle the load is presented. Expectations
// that depend on STORE_BUF_FWD_EN follow the same macro.
// ---------------------------------------------------------------------------
module tb_store_buffer;

`ifdef STORE_BUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int W = 66;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_mode;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [1:0]  ld_mode;
    logic        ld_conflict;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        mem_we;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        empty;

    logic [W-1:0] exp_q [$];
    int tests;
    int failed;

    store_buffer #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_mode     (st_mode),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_mode     (ld_mode),
        .ld_conflict (ld_conflict),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .mem_we      (mem_we),
        .mem_mode    (mem_mode),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .empty       (empty)
    );

    // ---------------------------------------------------------------- clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ checking
    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drain monitor: every memory write must be the oldest outstanding store.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && mem_we) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL drain_unexpected: got addr=%h mode=%b data=%h expected no write",
                         mem_addr, mem_mode, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_mode, mem_wdata} !== e) begin
                    failed++;
                    $display("FAIL drain: got addr=%h mode=%b data=%h expected addr=%h mode=%b data=%h",
                             mem_addr, mem_mode, mem_wdata, e[65:34], e[33:32], e[31:0]);
                end
            end
        end
    end

    // -------------------------------------------------------------- drivers
    // All driver tasks start and end at posedge + 1.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] m);
        int n;
        n = 0;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_mode  = m;
        @(negedge clk);
        while (!st_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!st_ready) begin
            check("store_accept_timeout", 32'(st_ready), 32'd1);
        end else begin
            exp_q.push_back({a, m, d});
        end
        next_cycle();
        st_valid = 1'b0;
    endtask

    task automatic set_load(input logic v, input logic [31:0] a,
                            input logic [1:0] m);
        ld_valid = v;
        ld_addr  = a;
        ld_mode  = m;
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!empty && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(empty), 32'd1);
        next_cycle();
    endtask

    // Present a load for one cycle and check the load-side outputs.
    task automatic load_probe(input string nm, input logic [31:0] a,
                              input logic [1:0] m, input logic exp_hit,
                              input logic [31:0] exp_data,
                              input logic exp_conf);
        set_load(1'b1, a, m);
        @(negedge clk);
        check({nm, "_fwd_hit"},  32'(fwd_hit),     32'(exp_hit));
        check({nm, "_fwd_data"}, fwd_data,          exp_data);
        check({nm, "_conflict"}, 32'(ld_conflict), 32'(exp_conf));
        check({nm, "_mem_we"},   32'(mem_we),      32'(exp_conf));
        next_cycle();
        set_load(1'b0, 32'd0, 2'b00);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        tests    = 0;
        failed   = 0;
        rst      = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_mode  = '0;
        set_load(1'b0, 32'd0, 2'b00);
        repeat (3) next_cycle();

        // Reset values, sampled while reset is still applied.
        @(negedge clk);
        check("rst_st_ready",    32'(st_ready),    32'd1);
        check("rst_empty",       32'(empty),       32'd1);
        check("rst_mem_we",      32'(mem_we),      32'd0);
        check("rst_fwd_hit",     32'(fwd_hit),     32'd0);
        check("rst_ld_conflict", 32'(ld_conflict), 32'd0);
        check("rst_fwd_data",    fwd_data,         32'd0);
        check("rst_mem_wdata",   mem_wdata,        32'd0);
        next_cycle();
        rst = 1'b0;

        // Single word store drains the next cycle when idle.
        do_store(32'h10, 32'hDEADBEEF, 2'b10);
        wait_empty("word_store_drained");

        // Fill while a non-overlapping load holds the port.
        set_load(1'b1, 32'h1000, 2'b10);
        do_store(32'h100, 32'h0000_0001, 2'b10);
        do_store(32'h104, 32'h0000_0002, 2'b10);
        do_store(32'h108, 32'h0000_0003, 2'b01);
        do_store(32'h10C, 32'h0000_0004, 2'b00);
        // A store offered while full must not be captured.
        st_valid = 1'b1;
        st_addr  = 32'h999;
        st_data  = 32'hBAD0_BAD0;
        st_mode  = 2'b10;
        @(negedge clk);
        check("full_st_ready", 32'(st_ready), 32'd0);
        check("full_mem_we",   32'(mem_we),   32'd0);
        check("full_mem_addr", mem_addr,      32'h1000);
        check("full_empty",    32'(empty),    32'd0);
        next_cycle();
        st_valid = 1'b0;
        set_load(1'b0, 32'd0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fill_drain_back_to_back", 32'(mem_we), 32'd1);
            next_cycle();
        end
        wait_empty("fill_drained");

        // Byte forward with sign extension.
        do_store(32'h20, 32'h0000_0080, 2'b00);
        load_probe("byte_fwd", 32'h20, 2'b00, FWD,
                   FWD ? 32'hFFFF_FF80 : 32'd0, !FWD);
        wait_empty("byte_fwd_drained");

        // Halfword forward ignores the upper store bits.
        do_store(32'h50, 32'hABCD_8001, 2'b01);
        load_probe("half_fwd", 32'h50, 2'b01, FWD,
                   FWD ? 32'hFFFF_8001 : 32'd0, !FWD);
        wait_empty("half_fwd_drained");

        // Mode 11 stores behave as bytes and match a byte load.
        do_store(32'h60, 32'h0000_017F, 2'b11);
        load_probe("mode11_fwd", 32'h60, 2'b00, FWD,
                   FWD ? 32'h0000_007F : 32'd0, !FWD);
        wait_empty("mode11_drained");

        // Partial overlap: word store, halfword load inside it.
        do_store(32'h30, 32'h1234_5678, 2'b10);
        set_load(1'b1, 32'h32, 2'b01);
        @(negedge clk);
        check("partial_conflict", 32'(ld_conflict), 32'd1);
        check("partial_fwd_hit",  32'(fwd_hit),     32'd0);
        check("partial_drain_addr", mem_addr,       32'h30);
        next_cycle();
        @(negedge clk);
        check("partial_conflict_cleared", 32'(ld_conflict), 32'd0);
        check("partial_load_we",   32'(mem_we),   32'd0);
        check("partial_load_addr", mem_addr,      32'h32);
        check("partial_load_mode", 32'(mem_mode), 32'd1);
        next_cycle();
        set_load(1'b0, 32'd0, 2'b00);

        // Footprint boundary: 0x74 is just past a word at 0x70, 0x73 is inside.
        do_store(32'h70, 32'hCAFE_F00D, 2'b10);
        set_load(1'b1, 32'h74, 2'b00);
        @(negedge clk);
        check("edge_adjacent_conflict", 32'(ld_conflict), 32'd0);
        check("edge_adjacent_we",       32'(mem_we),      32'd0);
        check("edge_adjacent_addr",     mem_addr,         32'h74);
        next_cycle();
        set_load(1'b1, 32'h73, 2'b00);
        @(negedge clk);
        check("edge_inside_conflict", 32'(ld_conflict), 32'd1);
        next_cycle();
        set_load(1'b0, 32'd0, 2'b00);
        wait_empty("edge_drained");

        // Two bytes to the same address: the younger one is visible.
        set_load(1'b1, 32'h1000, 2'b10);
        do_store(32'h40, 32'h0000_0011, 2'b00);
        do_store(32'h40, 32'h0000_0022, 2'b00);
        set_load(1'b1, 32'h40, 2'b00);
`ifdef STORE_BUF_FWD_EN
        @(negedge clk);
        check("young_fwd_hit",  32'(fwd_hit),     32'd1);
        check("young_fwd_data", fwd_data,         32'h0000_0022);
        check("young_conflict", 32'(ld_conflict), 32'd0);
        check("young_mem_we",   32'(mem_we),      32'd0);
        next_cycle();
`else
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("young_conflict_held", 32'(ld_conflict), 32'd1);
            check("young_fwd_hit",       32'(fwd_hit),     32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("young_conflict_cleared", 32'(ld_conflict), 32'd0);
        check("young_load_addr",        mem_addr,         32'h40);
        next_cycle();
`endif
        set_load(1'b0, 32'd0, 2'b00);
        wait_empty("young_drained");

        // Reset while stores are pending discards them.
        set_load(1'b1, 32'h1000, 2'b10);
        do_store(32'h200, 32'h5555_5555, 2'b10);
        do_store(32'h204, 32'h6666_6666, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        next_cycle();
        rst = 1'b0;
        set_load(1'b0, 32'd0, 2'b00);
        @(negedge clk);
        check("midrst_empty",    32'(empty),    32'd1);
        check("midrst_st_ready", 32'(st_ready), 32'd1);
        check("midrst_mem_we",   32'(mem_we),   32'd0);
        check("midrst_wdata",    mem_wdata,     32'd0);
        repeat (3) next_cycle();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store buffer between the execute stage and the byte-addressable data memory. Accepts byte/halfword/word stores, holds up to DEPTH in program order and retires one per cycle into the memory's single address/write port. Loads get the port unless a buffered store overlaps them. Exact-match loads are served by store-to-load forwarding.

## Interface
- DEPTH, 4, entry count (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request
- st_ready  out  1  buffer can accept (= !full)
- st_addr  in  32  store byte address
- st_data  in  32  store data, LSB-aligned
- st_mode  in  2  00 byte, 01 halfword, 10 word (11 treated as byte)
- ld_valid  in  1  load wants the memory port this cycle
- ld_addr  in  32  load byte address
- ld_mode  in  2  load size, same encoding
- ld_conflict  out  1  load overlaps a buffered store not forwardable; caller must stall
- fwd_hit  out  1  load served from buffer
- fwd_data  out  32  forwarded data, sign-extended like memory reads
- mem_we  out  1  memory write enable
- mem_mode  out  2  memory access size
- mem_addr  out  32  memory address (load or drain)
- mem_wdata  out  32  memory write data
- empty  out  1  no entries (fence/drain status)

## Operation
- Circular FIFO: head, tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count 0..DEPTH.
- Enqueue when st_valid && st_ready: entry{addr,data,mode} written at tail, tail+1.
- Size: byte=1, halfword=2, word=4 bytes; mode 11 → 1. Footprint [addr, addr+size-1], 32-bit compare, no wrap handling.
- Overlap: load footprint intersects any valid entry's footprint.
- Exact match: entry addr == ld_addr and size equal.
- Forward: ld_valid, youngest overlapping entry is exact match → fwd_hit=1, fwd_data = entry data with byte sign-extended from bit 7, halfword from bit 15, word as-is.
- ld_conflict = ld_valid && overlap && !fwd_hit.
- Port arbitration each cycle:
  - empty → mem_we=0, mem_addr=ld_addr, mem_mode=ld_mode.
  - ld_valid && !ld_conflict → load owns port: mem_addr=ld_addr, mem_mode=ld_mode, mem_we=0, no drain.
  - otherwise (no load, or conflict) → drain: mem_we=1, mem_addr/mem_mode/mem_wdata from head; head+1 at edge.
- mem_wdata = head data whenever non-empty, else 0.
- Simultaneous enqueue + drain: count unchanged; allowed when full only if drain occurs? No — st_ready = !full strictly, no pass-through.
- Store with st_valid while !st_ready: held by upstream, not captured.
- Reset: count=0, head=tail=0, entries invalid; st_ready=1, empty=1, mem_we=0, fwd_hit=0, ld_conflict=0, fwd_data=0, mem_wdata=0. Reset mid-drain discards all pending stores.

## Timing
- Store accepted at edge N is visible to forwarding/overlap in cycle N+1 (combinational on entries).
- Earliest drain: cycle N+1 (mem_we asserted), memory updated at edge N+2.
- Drain throughput: one store/cycle when no load owns the port.
- Forwarding and ld_conflict are combinational, same cycle as ld_valid.
- Conflict resolves within ≤ count cycles; forced drain guarantees progress (no deadlock).
- Entry drained at edge E no longer participates in overlap from cycle after E.

## Configuration
- STORE_BUF_FWD_EN defined: forwarding as above.
- Not defined: fwd_hit=0, fwd_data=0; any overlap asserts ld_conflict; forwarding comparators/extension logic absent.

## Test plan
- Reset, word store 0x10←0xDEADBEEF, idle → mem_we=1, mem_addr=0x10, mem_mode=10 one cycle later; empty=1 after.
- Fill 4 stores with ld_valid held low-priority blocked (ld_valid=1 no overlap) → st_ready=0 after 4th, mem_we=0; drop ld_valid → 4 consecutive drains in order.
- Byte store 0x20←0x80, load byte 0x20 → fwd_hit=1, fwd_data=0xFFFFFF80, ld_conflict=0 (with STORE_BUF_FWD_EN).
- Word store 0x30, load halfword 0x32 → ld_conflict=1, drain forced; conflict drops after store retires, load reads memory.
- Two stores to 0x40 (0x11 then 0x22, byte), byte load 0x40 → fwd_data=0x22 (youngest wins).
- Without STORE_BUF_FWD_EN, exact-match load → fwd_hit=0, ld_conflict=1 until drained.
